// File: rtl/l2cache_axi_bridge.sv
// ============================================================================
// Module   : l2cache_axi_bridge
// Purpose  : Converts L2 line refills and write-backs into AXI4 INCR bursts
//            of (1<<offset_width) 32-bit beats. The read and write FSMs are
//            independent, and each side has at most one transaction in
//            flight. Writes are posted, so the L2 is released as soon as its
//            line is captured. A read is accepted only while the write side
//            is idle, so a refill can never overtake its own eviction.
// Ports    : clk, rst                - clock, synchronous active-high reset
//            addr/dout/wstrb/req_*   - L2 request side (line-aligned)
//            din/addrOK_*/dataOK/rdy - L2 handshake and returned line
//            axi_ar* / axi_r*        - AXI4 read address / read data
//            axi_aw* / axi_w* / axi_b* - AXI4 write address / data / response
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2cache_axi_bridge #(
  parameter int offset_width = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  addr_l2cache_mem_r,
  input  logic [31:0]                  addr_l2cache_mem_w,
  input  logic [(32<<offset_width)-1:0] dout_l2cache_mem,
  input  logic [3:0]                   l2cache_mem_wstrb,
  input  logic                         l2cache_mem_req_r,
  input  logic                         l2cache_mem_req_w,
  input  logic                         l2cache_mem_rdy,
  output logic [(32<<offset_width)-1:0] din_mem_l2cache,
  output logic                         mem_l2cache_addrOK_r,
  output logic                         mem_l2cache_addrOK_w,
  output logic                         mem_l2cache_dataOK,
  output logic [31:0]                  axi_araddr,
  output logic [7:0]                   axi_arlen,
  output logic [2:0]                   axi_arsize,
  output logic [1:0]                   axi_arburst,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  input  logic [31:0]                  axi_rdata,
  input  logic                         axi_rlast,
  input  logic                         axi_rvalid,
  output logic                         axi_rready,
  output logic [31:0]                  axi_awaddr,
  output logic [7:0]                   axi_awlen,
  output logic [2:0]                   axi_awsize,
  output logic [1:0]                   axi_awburst,
  output logic                         axi_awvalid,
  input  logic                         axi_awready,
  output logic [31:0]                  axi_wdata,
  output logic [3:0]                   axi_wstrb,
  output logic                         axi_wlast,
  output logic                         axi_wvalid,
  input  logic                         axi_wready,
  input  logic                         axi_bvalid,
  output logic                         axi_bready
);

  localparam int BEATS = 1 << offset_width;
  localparam logic [offset_width-1:0] CNT_MAX = offset_width'(BEATS - 1);

  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RESP} rstate_t;

  wstate_t wstate, wstate_next;
  rstate_t rstate, rstate_next;

  logic [31:0]                   waddr, raddr;
  logic [BEATS-1:0][31:0]        wline, rline;
  logic [3:0]                    wstrb_q;
  logic [offset_width-1:0]       wcnt, rcnt;
  logic                          w_accept, r_accept, w_beat, r_beat;

  // Writes win a simultaneous request; a read also waits out any write in flight.
  assign w_accept = (wstate == W_IDLE) && l2cache_mem_req_w;
  assign r_accept = (rstate == R_IDLE) && (wstate == W_IDLE) &&
                    !l2cache_mem_req_w && l2cache_mem_req_r;
  assign w_beat   = (wstate == W_DATA) && axi_wready;
  assign r_beat   = (rstate == R_DATA) && axi_rvalid;

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_next;
      rstate <= rstate_next;
    end
  end

  always_comb begin
    wstate_next = wstate;
    case (wstate)
      W_IDLE:  if (w_accept) wstate_next = W_AW;
      W_AW:    if (axi_awready) wstate_next = W_DATA;
      W_DATA:  if (w_beat && (wcnt == CNT_MAX)) wstate_next = W_B;
      W_B:     if (axi_bvalid) wstate_next = W_IDLE;
      default: wstate_next = W_IDLE;
    endcase
  end

  // A missing rlast must not hang the bridge: the final counted beat also ends the burst.
  always_comb begin
    rstate_next = rstate;
    case (rstate)
      R_IDLE:  if (r_accept) rstate_next = R_AR;
      R_AR:    if (axi_arready) rstate_next = R_DATA;
      R_DATA:  if (r_beat && (axi_rlast || (rcnt == CNT_MAX))) rstate_next = R_RESP;
      R_RESP:  if (l2cache_mem_rdy) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr   <= '0;
      wline   <= '0;
      wstrb_q <= '0;
      wcnt    <= '0;
      raddr   <= '0;
      rline   <= '0;
      rcnt    <= '0;
    end else begin
      if (w_accept) begin
        waddr   <= addr_l2cache_mem_w;
        wline   <= dout_l2cache_mem;
        wstrb_q <= l2cache_mem_wstrb;
        wcnt    <= '0;
      end else if (w_beat) begin
        wcnt <= wcnt + 1'b1;
      end

      if (r_accept) begin
        raddr <= addr_l2cache_mem_r;
        rcnt  <= '0;
      end else if (r_beat) begin
        rline[rcnt] <= axi_rdata;
        rcnt        <= rcnt + 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
  assign mem_l2cache_addrOK_w = w_accept;
  assign mem_l2cache_addrOK_r = r_accept;
  assign mem_l2cache_dataOK   = (rstate == R_RESP);
  assign din_mem_l2cache      = rline;

  assign axi_araddr  = raddr;
  assign axi_arlen   = 8'(BEATS - 1);
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_arvalid = (rstate == R_AR);
  assign axi_rready  = (rstate == R_DATA);

  assign axi_awaddr  = waddr;
  assign axi_awlen   = 8'(BEATS - 1);
  assign axi_awsize  = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awvalid = (wstate == W_AW);
  assign axi_wvalid  = (wstate == W_DATA);
  assign axi_wdata   = wline[wcnt];
  assign axi_wstrb   = wstrb_q;
  assign axi_wlast   = (wstate == W_DATA) && (wcnt == CNT_MAX);
  assign axi_bready  = (wstate == W_B);

endmodule

`default_nettype wire

// File: tb/tb_l2cache_axi_bridge.sv
`timescale 1ns/1ps
`default_nettype none

module tb_l2cache_axi_bridge;

  localparam int OW = 2;
  localparam int LW = 32 << OW;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr_r, addr_w;
  logic [LW-1:0] dout_line;
  logic [3:0]    wstrb_in;
  logic          req_r, req_w, rdy;
  logic [LW-1:0] din_line;
  logic          addr_ok_r, addr_ok_w, data_ok;
  logic [31:0]   axi_araddr, axi_awaddr, axi_rdata, axi_wdata;
  logic [7:0]    axi_arlen, axi_awlen;
  logic [2:0]    axi_arsize, axi_awsize;
  logic [1:0]    axi_arburst, axi_awburst;
  logic          axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic          axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic [3:0]    axi_wstrb;
  logic          axi_bvalid, axi_bready;

  always #5 clk = ~clk;

  l2cache_axi_bridge #(.offset_width(OW)) dut (
    .clk(clk), .rst(rst),
    .addr_l2cache_mem_r(addr_r), .addr_l2cache_mem_w(addr_w),
    .dout_l2cache_mem(dout_line), .l2cache_mem_wstrb(wstrb_in),
    .l2cache_mem_req_r(req_r), .l2cache_mem_req_w(req_w), .l2cache_mem_rdy(rdy),
    .din_mem_l2cache(din_line), .mem_l2cache_addrOK_r(addr_ok_r),
    .mem_l2cache_addrOK_w(addr_ok_w), .mem_l2cache_dataOK(data_ok),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  // ---------------- scoreboard state ----------------
  logic [LW-1:0] rsrc_q[$];       // data the slave returns, one line per AR
  logic [LW-1:0] exp_rline_q[$];  // line the L2 must see on dataOK
  logic [31:0]   exp_ar_q[$], exp_aw_q[$];
  logic [36:0]   exp_w_q[$];      // {strb, data, last} per W beat
  int            lat_q[$];        // expected cycle of dataOK rising
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, b_cycle = 0, rbeats = 0, aw_stall_cfg = 0;
  bit            rand_bp = 0, rdy_cmd = 1, rdy_rand = 0, w_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;
  assign rdy = rand_bp ? rdy_rand : rdy_cmd;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic chk_quiet(input string tag);
    cmp({tag, "_ctrl"}, 128'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                              addr_ok_r, addr_ok_w, data_ok}), 128'd0);
    cmp({tag, "_line"}, din_line, 128'd0);
  endtask

  // ---------------- AXI slave model + channel checks ----------------
  initial begin : slave
    logic [3:0][31:0] cur;
    logic [36:0]      e;
    bit               ar_f, r_f, aw_f, w_f, b_f, rst_s, r_act, aw_seen, b_pend;
    int               wbeats, aw_wait;
    r_act = 0; aw_seen = 0; b_pend = 0; wbeats = 0; aw_wait = 0; cur = '0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rlast = 0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      ar_f = axi_arvalid && axi_arready;
      r_f  = axi_rvalid && axi_rready;
      aw_f = axi_awvalid && axi_awready;
      w_f  = axi_wvalid && axi_wready;
      b_f  = axi_bvalid && axi_bready;
      if (!rst_s) begin
        if (axi_wvalid) cmp("w_after_aw", 128'(aw_seen), 128'd1);
        if (addr_ok_w) w_busy = 1;
        if (ar_f) begin
          if (exp_ar_q.size() == 0) abort("unexpected_ar");
          cmp("araddr", 128'(axi_araddr), 128'(exp_ar_q.pop_front()));
          cmp("ar_fields", 128'({axi_arlen, axi_arsize, axi_arburst}), 128'({8'd3, 3'b010, 2'b01}));
          cur = (rsrc_q.size() != 0) ? rsrc_q.pop_front() : '0;
          rbeats = 0;
          r_act = 1;
        end
        if (r_f) begin
          rbeats++;
          if (rbeats == 4) r_act = 0;
        end
        if (aw_f) begin
          if (exp_aw_q.size() == 0) abort("unexpected_aw");
          cmp("awaddr", 128'(axi_awaddr), 128'(exp_aw_q.pop_front()));
          cmp("aw_fields", 128'({axi_awlen, axi_awsize, axi_awburst}), 128'({8'd3, 3'b010, 2'b01}));
          aw_seen = 1;
          wbeats = 0;
          aw_wait = 0;
        end else if (axi_awvalid) begin
          aw_wait++;
        end
        if (w_f) begin
          if (exp_w_q.size() == 0) abort("unexpected_w");
          e = exp_w_q.pop_front();
          cmp("wdata", 128'(axi_wdata), 128'(e[32:1]));
          cmp("wstrb", 128'(axi_wstrb), 128'(e[36:33]));
          cmp("wlast", 128'(axi_wlast), 128'(e[0]));
          wbeats++;
          if (axi_wlast) begin
            cmp("w_beat_count", 128'(wbeats), 128'd4);
            b_pend = 1;
          end
        end
        if (b_f) begin
          b_pend = 0;
          aw_seen = 0;
          w_busy = 0;
          b_cycle = cyc;
        end
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
        r_act = 0; aw_seen = 0; b_pend = 0; w_busy = 0; aw_wait = 0;
      end
      axi_arready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!(axi_rvalid && !r_f && !rst_s))
        axi_rvalid = r_act && (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
      axi_rdata   = cur[rbeats[1:0]];
      axi_rlast   = (rbeats == 3);
      axi_awready = rand_bp ? 1'($urandom_range(0, 1)) : (aw_wait >= aw_stall_cfg);
      axi_wready  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!(axi_bvalid && !b_f && !rst_s))
        axi_bvalid = b_pend && (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk);
      #1;
      rdy_rand = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- read-return monitor ----------------
  initial begin : monitor
    bit held;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) cmp("dataOK_held", 128'(data_ok), 128'd1);
        if (data_ok) begin
          if (!held) begin
            cmp("r_beat_count", 128'(rbeats), 128'd4);
            if (lat_q.size() != 0) cmp("dataOK_latency", 128'(cyc), 128'(lat_q.pop_front()));
          end
          if (exp_rline_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_dataOK: got line %h expected no read pending", din_line);
          end else begin
            cmp("read_line", din_line, exp_rline_q[0]);
            if (rdy) void'(exp_rline_q.pop_front());
          end
        end
        held = data_ok && !rdy;
      end
    end
  end

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  task automatic issue_read(input logic [31:0] a, input logic [LW-1:0] line,
                            input bit lat, input bit block, input int limit);
    int n = 0;
    rsrc_q.push_back(line);
    exp_ar_q.push_back(a);
    exp_rline_q.push_back(line);
    addr_r = a;
    req_r  = 1;
    while (1) begin
      @(negedge clk);
      if (block && n == 0) cmp("simul_only_w_ok", 128'({addr_ok_w, addr_ok_r}), 128'd2);
      if (addr_ok_r) break;
      n++;
      if (n > limit) abort("read_accept");
    end
    cmp("r_accept_write_idle", 128'(w_busy), 128'd0);
    if (block) cmp("r_accept_after_b", 128'(cyc), 128'(b_cycle + 1));
    if (lat) lat_q.push_back(cyc + 6);
    @(posedge clk);
    #1;
    req_r = 0;
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [LW-1:0] line,
                             input logic [3:0] strb, input int limit);
    int n = 0;
    exp_aw_q.push_back(a);
    for (int i = 0; i < 4; i++) exp_w_q.push_back({strb, line[i*32 +: 32], (i == 3)});
    addr_w    = a;
    dout_line = line;
    wstrb_in  = strb;
    req_w     = 1;
    while (1) begin
      @(negedge clk);
      if (addr_ok_w) break;
      n++;
      if (n > limit) abort("write_accept");
    end
    @(posedge clk);
    #1;
    req_w = 0;
  endtask

  task automatic wait_write_free(input int limit);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (!w_busy) break;
      n++;
      if (n > limit) abort("write_complete");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read_done(input int limit);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (exp_rline_q.size() == 0) break;
      n++;
      if (n > limit) abort("read_complete");
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    rst = 1; req_r = 0; req_w = 0; addr_r = 0; addr_w = 0; dout_line = '0; wstrb_in = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;
    rst = 0;

    // zero-wait read, latency and beat assembly
    issue_read(32'h1C00_0040, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 0, 20);
    wait_read_done(50);

    // write with AW stalled three cycles
    aw_stall_cfg = 3;
    issue_write(32'h0000_1000, {32'hDDDD_000D, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A}, 4'hF, 20);
    wait_write_free(50);
    aw_stall_cfg = 0;

    // simultaneous requests: write wins, read follows the B handshake
    fork
      issue_write(32'h0000_2000, {32'h4, 32'h3, 32'h2, 32'h1}, 4'h3, 20);
      issue_read(32'h0000_3000, {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 1, 1, 50);
    join
    wait_read_done(50);
    wait_write_free(50);

    // L2 not ready for five cycles after the line arrives
    rdy_cmd = 0;
    issue_read(32'h0000_5040, {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001}, 1, 0, 20);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (data_ok) break;
      n++;
      if (n > 50) abort("hold_dataOK");
    end
    repeat (5) @(posedge clk);
    #1;
    rdy_cmd = 1;
    @(posedge clk);
    @(negedge clk);
    cmp("line_stable_idle", din_line, {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001});
    @(posedge clk);
    #1;
    issue_read(32'h0000_6000, {32'h66, 32'h65, 32'h64, 32'h63}, 1, 0, 20);
    wait_read_done(50);

    // reset in the middle of a read burst (beat 2)
    issue_read(32'h0000_7000, {32'h77, 32'h76, 32'h75, 32'h74}, 0, 0, 20);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    exp_rline_q.delete();
    @(negedge clk);
    chk_quiet("mid_burst_reset");
    @(posedge clk);
    #1;
    issue_read(32'h0000_8000, {32'h88, 32'h87, 32'h86, 32'h85}, 1, 0, 20);
    wait_read_done(50);

    // mixed traffic under random backpressure
    rand_bp = 1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          issue_write($urandom & 32'hFFFF_FFF0, rand_line(), 4'($urandom_range(1, 15)), 1000);
          wait_write_free(1000);
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int j = 0; j < 100; j++) begin
          issue_read($urandom & 32'hFFFF_FFF0, rand_line(), 0, 0, 1000);
          wait_read_done(1000);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    join
    rand_bp = 0;
    wait_write_free(100);
    wait_read_done(100);
    cmp("w_queue_drained", 128'(exp_w_q.size()), 128'd0);
    cmp("aw_queue_drained", 128'(exp_aw_q.size()), 128'd0);
    cmp("ar_queue_drained", 128'(exp_ar_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
